unidade_mult_div: RTL and testbench

Multi-cycle multiply/divide unit on the operand path downstream of the register bank. It captures the two register operands L1/L2 on a start pulse from the control unit (UC) and runs a 32-iteration shift-add multiply or restoring divide. It then presents a 64-bit result in Hi/Lo registers, which feed the write-data multiplexer. Ocupado tells the UC to stall while an operation is in flight.

---
 rtl/unidade_mult_div.sv | 156 +++++++++++++++
 tb/tb_unidade_mult_div.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/unidade_mult_div.sv
// Multi-cycle 32x32 multiply / restoring divide unit with Hi/Lo result registers.
// Operands are latched as magnitudes on accept; the sign is fixed up once at the end.
module unidade_mult_div (
  input  logic        clock,
  input  logic        reset,
  input  logic        Start_UC,
  input  logic [1:0]  Op_UC,
  input  logic [31:0] L1,
  input  logic [31:0] L2,
  output logic [31:0] Hi,
  output logic [31:0] Lo,
  output logic        Ocupado,
  output logic        Pronto,
  output logic        Div_Zero
);

  typedef enum logic [1:0] {IDLE, CALC, FIM} state_t;

  state_t      state_reg, state_next;
  logic        div_reg, div_next;
  logic        neg_q_reg, neg_q_next;
  logic        neg_r_reg, neg_r_next;
  logic        dz_pend_reg, dz_pend_next;
  logic [5:0]  cnt_reg, cnt_next;
  logic [31:0] opnd_reg, opnd_next;
  logic [63:0] acc_reg, acc_next;
  logic [31:0] hi_reg, hi_next;
  logic [31:0] lo_reg, lo_next;
  logic        pronto_reg, pronto_next;
  logic        dz_reg, dz_next;
  logic        ocup_reg, ocup_next;

  logic        is_signed, is_div;
  logic [31:0] mag_a, mag_b;
  logic [32:0] msum;
  logic [63:0] mul_step;
  logic [32:0] rem_sh;
  logic        ge;
  logic [31:0] diff;
  logic [63:0] div_step;
  logic [63:0] prod_fix;

  assign is_signed = ~Op_UC[0];
  assign is_div    = Op_UC[1];
  assign mag_a     = (is_signed && L1[31]) ? -L1 : L1;
  assign mag_b     = (is_signed && L2[31]) ? -L2 : L2;

  // Multiply: acc = {partial sum, remaining multiplier}, shifted right each step.
  assign msum     = {1'b0, acc_reg[63:32]} + (acc_reg[0] ? {1'b0, opnd_reg} : 33'd0);
  assign mul_step = {msum, acc_reg[31:1]};

  // Divide: acc = {remainder, dividend -> quotient}; 33-bit trial keeps DIVU exact.
  assign rem_sh   = {acc_reg[63:32], acc_reg[31]};
  assign ge       = (rem_sh >= {1'b0, opnd_reg});
  assign diff     = rem_sh[31:0] - opnd_reg;
  assign div_step = {(ge ? diff : rem_sh[31:0]), acc_reg[30:0], ge};

  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;

  always_comb begin
    state_next   = state_reg;
    div_next     = div_reg;
    neg_q_next   = neg_q_reg;
    neg_r_next   = neg_r_reg;
    dz_pend_next = dz_pend_reg;
    cnt_next     = cnt_reg;
    opnd_next    = opnd_reg;
    acc_next     = acc_reg;
    hi_next      = hi_reg;
    lo_next      = lo_reg;
    pronto_next  = 1'b0;
    dz_next      = dz_reg;
    ocup_next    = ocup_reg;
    case (state_reg)
      IDLE: begin
        if (Start_UC) begin
          div_next  = is_div;
          cnt_next  = 6'd0;
          ocup_next = 1'b1;
          if (is_div && (L2 == 32'd0)) begin
            dz_pend_next = 1'b1;
            neg_q_next   = 1'b0;
            neg_r_next   = 1'b0;
            acc_next     = {L1, 32'hFFFF_FFFF};
            state_next   = FIM;
          end else begin
            dz_pend_next = 1'b0;
            neg_q_next   = is_signed & (L1[31] ^ L2[31]);
            neg_r_next   = is_signed & L1[31];
            opnd_next    = is_div ? mag_b : mag_a;
            acc_next     = is_div ? {32'd0, mag_a} : {32'd0, mag_b};
            state_next   = CALC;
          end
        end
      end
      CALC: begin
        acc_next = div_reg ? div_step : mul_step;
        cnt_next = cnt_reg + 6'd1;
        if (cnt_reg == 6'd31) state_next = FIM;
      end
      FIM: begin
        if (div_reg) begin
          hi_next = neg_r_reg ? -acc_reg[63:32] : acc_reg[63:32];
          lo_next = neg_q_reg ? -acc_reg[31:0] : acc_reg[31:0];
        end else begin
          hi_next = prod_fix[63:32];
          lo_next = prod_fix[31:0];
        end
        pronto_next = 1'b1;
        dz_next     = dz_pend_reg;
        ocup_next   = 1'b0;
        state_next  = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      div_reg     <= 1'b0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      dz_pend_reg <= 1'b0;
      cnt_reg     <= 6'd0;
      opnd_reg    <= 32'd0;
      acc_reg     <= 64'd0;
      hi_reg      <= 32'd0;
      lo_reg      <= 32'd0;
      pronto_reg  <= 1'b0;
      dz_reg      <= 1'b0;
      ocup_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      div_reg     <= div_next;
      neg_q_reg   <= neg_q_next;
      neg_r_reg   <= neg_r_next;
      dz_pend_reg <= dz_pend_next;
      cnt_reg     <= cnt_next;
      opnd_reg    <= opnd_next;
      acc_reg     <= acc_next;
      hi_reg      <= hi_next;
      lo_reg      <= lo_next;
      pronto_reg  <= pronto_next;
      dz_reg      <= dz_next;
      ocup_reg    <= ocup_next;
    end
  end

  assign Hi       = hi_reg;
  assign Lo       = lo_reg;
  assign Pronto   = pronto_reg;
  assign Div_Zero = dz_reg;
  assign Ocupado  = ocup_reg;

endmodule

// File: tb/tb_unidade_mult_div.sv
// Scoreboard bench for unidade_mult_div: expected Hi/Lo/Div_Zero/latency queued at accept,
// popped and compared on every Pronto pulse.
module tb_unidade_mult_div;

  logic        clock = 1'b0;
  logic        reset;
  logic        Start_UC;
  logic [1:0]  Op_UC;
  logic [31:0] L1, L2;
  logic [31:0] Hi, Lo;
  logic        Ocupado, Pronto, Div_Zero;

  localparam logic [1:0] MULT = 2'd0, MULTU = 2'd1, DIV = 2'd2, DIVU = 2'd3;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
    int          acc_cyc;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;

  unidade_mult_div dut (
    .clock    (clock),
    .reset    (reset),
    .Start_UC (Start_UC),
    .Op_UC    (Op_UC),
    .L1       (L1),
    .L2       (L2),
    .Hi       (Hi),
    .Lo       (Lo),
    .Ocupado  (Ocupado),
    .Pronto   (Pronto),
    .Div_Zero (Div_Zero)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic dz);
    logic signed [63:0] sa, sb2, sr;
    logic [63:0] ua, ub, ur;
    sa  = {{32{a[31]}}, a};
    sb2 = {{32{b[31]}}, b};
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    dz  = 1'b0;
    hi  = 32'd0;
    lo  = 32'd0;
    case (op)
      MULT:  begin sr = sa * sb2; {hi, lo} = sr; end
      MULTU: begin ur = ua * ub;  {hi, lo} = ur; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; dz = 1'b1;
        end else if (op == DIV) begin
          sr = sa / sb2; lo = sr[31:0];
          sr = sa % sb2; hi = sr[31:0];
        end else begin
          ur = ua / ub; lo = ur[31:0];
          ur = ua % ub; hi = ur[31:0];
        end
      end
    endcase
  endfunction

  // Drives a request now (away from the edge), returns just after the accept edge.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    exp_t e;
    Start_UC = 1'b1; Op_UC = op; L1 = a; L2 = b;
    @(posedge clock); #1;
    e.op = op; e.a = a; e.b = b; e.hi = hi; e.lo = lo; e.dz = dz;
    e.acc_cyc = cyc;
    e.lat = (op[1] && b == 32'd0) ? 1 : 33;
    sb.push_back(e);
    Start_UC = 1'b0;
    L1 = $urandom; L2 = $urandom; Op_UC = 2'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 100; i++) begin
      @(negedge clock); #1;
      if (sb.size() == 0) return;
    end
    check_val("timeout", 1, 0);
    sb.delete();
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] hi, input logic [31:0] lo, input logic dz);
    start_op(op, a, b, hi, lo, dz);
    wait_done();
  endtask

  always @(negedge clock) begin
    if (Pronto) begin
      if (sb.size() == 0) begin
        check_val("spurious_pronto", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check_val("hi", Hi, mon_e.hi);
        check_val("lo", Lo, mon_e.lo);
        check_val("div_zero", Div_Zero, mon_e.dz);
        check_val("latency", 64'(cyc - mon_e.acc_cyc), 64'(mon_e.lat));
        check_val("ocupado_at_pronto", Ocupado, 0);
        $display("txn op=%0d a=%h b=%h hi=%h lo=%h dz=%0b lat=%0d",
                 mon_e.op, mon_e.a, mon_e.b, Hi, Lo, Div_Zero, cyc - mon_e.acc_cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rh, rl, ra, rb;
    logic        rdz;
    logic [1:0]  rop;
    reset = 1'b1; Start_UC = 1'b0; Op_UC = 2'd0; L1 = 32'd0; L2 = 32'd0;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_hi", Hi, 0);
    check_val("rst_lo", Lo, 0);
    check_val("rst_ocupado", Ocupado, 0);
    check_val("rst_pronto", Pronto, 0);
    check_val("rst_div_zero", Div_Zero, 0);
    @(negedge clock);
    reset = 1'b0;

    // Directed cases, issued back to back on the Pronto cycle.
    run_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(MULT,  32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
    run_op(MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0);
    run_op(DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        1'b0);
    run_op(DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, 1'b1);
    repeat (3) @(negedge clock);
    check_val("div_zero_hold", Div_Zero, 1);
    run_op(MULTU, 32'd2,         32'd3,         32'd0,         32'd6,         1'b0);
    run_op(DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 1'b0);
    run_op(DIV,   32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, 1'b1);
    run_op(DIVU,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 8; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = (i == 3) ? 32'd0 : ((i % 2 == 1) ? 32'($urandom_range(1, 20)) : $urandom);
      model(rop, ra, rb, rh, rl, rdz);
      run_op(rop, ra, rb, rh, rl, rdz);
    end

    // Start requests while busy must be ignored.
    start_op(MULTU, 32'h10, 32'h20, 32'd0, 32'h200, 1'b0);
    for (int i = 0; i < 33; i++) begin
      @(negedge clock);
      check_val("ocupado_busy", Ocupado, 1);
      Start_UC = (i == 5 || i == 20);
      Op_UC = DIV; L1 = $urandom; L2 = $urandom;
    end
    Start_UC = 1'b0;
    wait_done();
    repeat (40) @(negedge clock);

    // Reset mid-divide aborts without Pronto; reset beats a simultaneous start.
    start_op(DIV, 32'd1000, 32'd3, 32'd1, 32'd333, 1'b0);
    repeat (10) @(negedge clock);
    reset = 1'b1;
    sb.delete();
    @(posedge clock); #1;
    check_val("abort_ocupado", Ocupado, 0);
    check_val("abort_hi", Hi, 0);
    check_val("abort_lo", Lo, 0);
    check_val("abort_pronto", Pronto, 0);
    @(negedge clock);
    Start_UC = 1'b1; Op_UC = MULTU; L1 = 32'd9; L2 = 32'd9;
    @(posedge clock); #1;
    check_val("reset_beats_start", Ocupado, 0);
    @(negedge clock);
    Start_UC = 1'b0; reset = 1'b0;
    repeat (3) @(negedge clock);
    check_val("idle_after_reset", Ocupado, 0);
    run_op(MULTU, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
    repeat (5) @(negedge clock);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
